// File: rtl/muller_c_bank.sv
// ---------------------------------------------------------------------------
// muller_c_bank
//
// Clocked model of a bank of NCH independent Muller C-elements, each with
// NIN inputs. Every input bit passes through a SYNC_STAGES-deep synchroniser.
// Each channel evaluates on the rising clock edge while its enable is high:
//   - all synchronised inputs high -> output goes high
//   - "all low" condition          -> output goes low
//   - otherwise                    -> output holds
// In asymmetric mode (mode_i[c]=1), bit 0 of the channel only takes part in
// the rising condition, so the falling condition looks at bits NIN-1..1 only.
// Each channel also produces registered one-cycle rise/fall pulses and keeps
// a saturating transition counter.
//
// Ports:
//   wb_clk_i   system clock, all state changes on its rising edge
//   wb_rst_i   synchronous active-high reset
//   in_i       channel c inputs at in_i[c*NIN +: NIN]
//   en_i       per-channel evaluate enable (0 = hold)
//   mode_i     per-channel mode: 0 symmetric, 1 asymmetric (bit 0 plus-only)
//   cnt_clr_i  synchronous clear of all transition counters
//   c_o        registered C-element outputs
//   rise_o     one-cycle pulse in the first cycle c_o[c] reads 1 after a 0
//   fall_o     one-cycle pulse in the first cycle c_o[c] reads 0 after a 1
//   cnt_o      channel c transition count at cnt_o[c*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module muller_c_bank #(
    parameter int               NCH         = 2,
    parameter int               NIN         = 3,
    parameter int               SYNC_STAGES = 2,
    parameter int               CNT_W       = 8,
    parameter logic [NCH-1:0]   RST_VAL     = '0
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NCH*NIN-1:0]     in_i,
    input  logic [NCH-1:0]         en_i,
    input  logic [NCH-1:0]         mode_i,
    input  logic                   cnt_clr_i,
    output logic [NCH-1:0]         c_o,
    output logic [NCH-1:0]         rise_o,
    output logic [NCH-1:0]         fall_o,
    output logic [NCH*CNT_W-1:0]   cnt_o
);

    localparam int SW = NCH * NIN;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Synchronised view of in_i, one NIN-bit slice per channel.
    logic [SW-1:0] s_w;

    // -----------------------------------------------------------------------
    // Input synchroniser. With zero stages the raw inputs feed evaluation
    // directly; otherwise a shift chain of SYNC_STAGES flops per bit.
    // -----------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_w = in_i;
        end else begin : g_sync
            logic [SW-1:0] sync_q [SYNC_STAGES];
            logic [SW-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = in_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            // The chain keeps shifting whether or not a channel is enabled,
            // so re-enabling sees the current synchronised inputs.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_d[i];
                    end
                end
            end

            assign s_w = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Per-channel C-element, pulse generation and transition counter.
    // -----------------------------------------------------------------------
    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic [NIN-1:0]   s_ch;
            logic             set_w;
            logic             clr_w;
            logic             c_q, c_d;
            logic             rise_q, rise_d;
            logic             fall_q, fall_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            assign s_ch  = s_w[c*NIN +: NIN];
            assign set_w = &s_ch;
            // Asymmetric mode ignores bit 0 for the falling condition. With
            // NIN >= 2 set and clear can never both be true.
            assign clr_w = mode_i[c] ? ~|s_ch[NIN-1:1] : ~|s_ch;

            always_comb begin
                c_d = c_q;
                if (en_i[c]) begin
                    if (set_w) begin
                        c_d = 1'b1;
                    end else if (clr_w) begin
                        c_d = 1'b0;
                    end
                end

                // Pulses only on a real change; a set/clear that matches the
                // current state produces nothing.
                rise_d = c_d & ~c_q;
                fall_d = ~c_d & c_q;

                // Clear wins over a simultaneous transition; the counter
                // saturates instead of wrapping.
                cnt_d = cnt_q;
                if (cnt_clr_i) begin
                    cnt_d = '0;
                end else if ((rise_d | fall_d) && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Reset loads RST_VAL without counting it as a transition.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    c_q    <= RST_VAL[c];
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    c_q    <= c_d;
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign c_o[c]                 = c_q;
            assign rise_o[c]              = rise_q;
            assign fall_o[c]              = fall_q;
            assign cnt_o[c*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

endmodule

// File: tb/tb_muller_c_bank.sv
// ---------------------------------------------------------------------------
// tb_muller_c_bank
//
// Two instances share clock, reset and stimulus: dut_a with RST_VAL=2'b00 and
// dut_b with RST_VAL=2'b10. A small behavioural model is stepped at every
// rising edge and its expected outputs for both instances are pushed to
// exp_q; the entry is popped and compared against the DUTs on the following
// falling edge. Directed checks with hand-derived constants follow the test
// plan steps.
// ---------------------------------------------------------------------------
module tb_muller_c_bank;

    localparam int NCH = 2;
    localparam int NIN = 3;
    localparam int CW  = 8;
    localparam int VW  = 44;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NCH*NIN-1:0] in_v;
    logic [NCH-1:0]    en_v;
    logic [NCH-1:0]    mode_v;
    logic              clr_v;

    logic [NCH-1:0]    c_a, rise_a, fall_a;
    logic [NCH*CW-1:0] cnt_a;
    logic [NCH-1:0]    c_b, rise_b, fall_b;
    logic [NCH*CW-1:0] cnt_b;

    muller_c_bank #(.NCH(2), .NIN(3), .SYNC_STAGES(2), .CNT_W(8), .RST_VAL(2'b00)) dut_a (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .in_i      (in_v),
        .en_i      (en_v),
        .mode_i    (mode_v),
        .cnt_clr_i (clr_v),
        .c_o       (c_a),
        .rise_o    (rise_a),
        .fall_o    (fall_a),
        .cnt_o     (cnt_a)
    );

    muller_c_bank #(.NCH(2), .NIN(3), .SYNC_STAGES(2), .CNT_W(8), .RST_VAL(2'b10)) dut_b (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .in_i      (in_v),
        .en_i      (en_v),
        .mode_i    (mode_v),
        .cnt_clr_i (clr_v),
        .c_o       (c_b),
        .rise_o    (rise_b),
        .fall_o    (fall_b),
        .cnt_o     (cnt_b)
    );

    // Scoreboard
    logic [VW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    logic [5:0] m_s1, m_s2;
    logic [1:0] m_c [2];
    logic [1:0] m_r [2];
    logic [1:0] m_f [2];
    logic [7:0] m_cnt [2][2];

    function automatic logic [VW-1:0] exp_vec();
        return {m_c[0], m_r[0], m_f[0], m_cnt[0][1], m_cnt[0][0],
                m_c[1], m_r[1], m_f[1], m_cnt[1][1], m_cnt[1][0]};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {c_a, rise_a, fall_a, cnt_a, c_b, rise_b, fall_b, cnt_b};
    endfunction

    // Model of one rising edge, using the inputs as they stand at that edge.
    task automatic model_step();
        logic [2:0] v;
        logic       cur;
        logic       nxt;
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            m_c[0] = 2'b00;
            m_c[1] = 2'b10;
            for (int i = 0; i < 2; i++) begin
                m_r[i] = '0;
                m_f[i] = '0;
                m_cnt[i][0] = '0;
                m_cnt[i][1] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                for (int ch = 0; ch < 2; ch++) begin
                    v   = m_s2[ch*3 +: 3];
                    cur = m_c[i][ch];
                    nxt = cur;
                    if (en_v[ch]) begin
                        if (v == 3'b111) nxt = 1'b1;
                        else if (mode_v[ch] ? (v[2:1] == 2'b00) : (v == 3'b000)) nxt = 1'b0;
                    end
                    m_r[i][ch] = nxt && !cur;
                    m_f[i][ch] = !nxt && cur;
                    if (clr_v) m_cnt[i][ch] = 8'd0;
                    else if ((nxt != cur) && (m_cnt[i][ch] != 8'd255)) m_cnt[i][ch] = m_cnt[i][ch] + 8'd1;
                    m_c[i][ch] = nxt;
                end
            end
            m_s2 = m_s1;
            m_s1 = in_v;
        end
        exp_q.push_back(exp_vec());
    endtask

    task automatic sb_check();
        logic [VW-1:0] e;
        logic [VW-1:0] o;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL sb_empty observed=no_entry expected=one_entry");
        end else begin
            e = exp_q.pop_front();
            o = obs_vec();
            assert (o === e) else begin
                bad++;
                $error("FAIL scoreboard observed=%h expected=%h", o, e);
            end
        end
    endtask

    // Driver: advance n cycles; model at each rising edge, compare at the
    // following falling edge. Stimulus changes happen at falling edges.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            sb_check();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        in_v   = '0;
        en_v   = '0;
        mode_v = '0;
        clr_v  = 1'b0;
        tick(2);
        chk("reset_c_a", c_a, 2'b00);
        chk("reset_c_b", c_b, 2'b10);
        chk("reset_cnt_a", cnt_a, 16'd0);
        chk("reset_pulses", {rise_a, fall_a, rise_b, fall_b}, 8'd0);

        // 1. Hold after reset
        rst    = 1'b0;
        in_v   = 6'b110011;
        en_v   = 2'b11;
        mode_v = 2'b00;
        tick(20);
        chk("t1_hold_c", c_a, 2'b00);
        chk("t1_cnt", cnt_a, 16'd0);

        // 2. Rise/fall latency on ch0
        in_v = 6'b000111;
        tick(3);
        chk("t2_rise", {c_a[0], rise_a[0]}, 2'b11);
        tick(1);
        chk("t2_rise_end", {c_a[0], rise_a[0]}, 2'b10);
        chk("t2_cnt1", cnt_a[7:0], 8'd1);
        in_v = 6'b000101;
        tick(5);
        chk("t2_hold", c_a[0], 1'b1);
        in_v = 6'b000000;
        tick(3);
        chk("t2_fall", {c_a[0], fall_a[0]}, 2'b01);
        chk("t2_cnt2", cnt_a[7:0], 8'd2);

        // 3. Asymmetric mode on ch1
        mode_v = 2'b10;
        in_v   = 6'b111000;
        tick(3);
        chk("t3_set", c_a[1], 1'b1);
        in_v = 6'b001000;
        tick(3);
        chk("t3_asym_fall", {c_a[1], fall_a[1]}, 2'b01);
        in_v = 6'b111000;
        tick(3);
        mode_v = 2'b00;
        in_v   = 6'b001000;
        tick(5);
        chk("t3_sym_hold", c_a[1], 1'b1);

        // 4. Enable gating on ch0
        en_v = 2'b10;
        in_v = 6'b001111;
        tick(10);
        chk("t4_gated", {c_a[0], rise_a[0]}, 2'b00);
        chk("t4_cnt", cnt_a[7:0], 8'd2);
        en_v = 2'b11;
        tick(1);
        chk("t4_reenable", {c_a[0], rise_a[0]}, 2'b11);
        chk("t4_cnt3", cnt_a[7:0], 8'd3);

        // 5. Saturation: 300 back-to-back toggles on ch0
        for (int i = 0; i < 300; i++) begin
            in_v = (i % 2 == 0) ? 6'b001000 : 6'b001111;
            tick(1);
        end
        tick(5);
        chk("t5_sat", cnt_a[7:0], 8'd255);
        chk("t5_state", c_a[0], 1'b1);

        // Clear in the same cycle as a fall on ch0
        in_v = 6'b001000;
        tick(2);
        clr_v = 1'b1;
        tick(1);
        clr_v = 1'b0;
        chk("t5_clr_fall", {c_a[0], fall_a[0]}, 2'b01);
        chk("t5_clr_cnt", cnt_a, 16'd0);

        // 6. Build c_o=01 with ch0 count 5, then reset mid-operation
        in_v = 6'b000111; tick(1);
        in_v = 6'b000000; tick(1);
        in_v = 6'b000111; tick(1);
        in_v = 6'b000000; tick(1);
        in_v = 6'b000111; tick(1);
        tick(5);
        chk("t6_pre_c", c_a, 2'b01);
        chk("t6_pre_cnt", cnt_a[7:0], 8'd5);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_c_b", c_b, 2'b10);
        chk("t6_rst_c_a", c_a, 2'b00);
        chk("t6_rst_cnt", {cnt_a, cnt_b}, 32'd0);
        chk("t6_rst_pulses", {rise_a, fall_a, rise_b, fall_b}, 8'd0);
        rst  = 1'b0;
        in_v = 6'b000000;
        // Synchroniser flops are already 0 after reset, so the first
        // evaluation edge sees all-low inputs.
        tick(1);
        chk("t6_fall_b", {c_b, fall_b}, 4'b0010);
        chk("t6_cnt_b", cnt_b[15:8], 8'd1);
        chk("t6_quiet_a", {c_a, rise_a, fall_a}, 6'd0);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
